// File: rtl/poker_pkg.sv
// Shared constants, types and small helpers for the poker hand dealer.
package poker_pkg;

  localparam int          CARD_W    = 6;
  localparam int          HAND_SIZE = 5;
  localparam int          DECK_SIZE = 52;
  localparam logic [2:0]  SEL_CHIP  = 3'd5;
  localparam logic [15:0] LFSR_INIT = 16'hACE1;

  typedef logic [CARD_W-1:0] card_t;

  typedef enum logic [2:0] {IDLE, PICK, WRITE, CHIP, PAR, DONE} state_t;

  function automatic logic [2:0] popcount5(input logic [4:0] m);
    popcount5 = 3'd0;
    for (int i = 0; i < 5; i++) popcount5 = popcount5 + {2'b00, m[i]};
  endfunction

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [2:0] lowest5(input logic [4:0] m);
    lowest5 = 3'd0;
    for (int i = 4; i >= 0; i--) if (m[i]) lowest5 = 3'(i);
  endfunction

endpackage

// File: rtl/card_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used as the shuffle source.
module card_lfsr
  import poker_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        advance,
  output logic [15:0] value
);

  logic fb;
  assign fb = value[15] ^ value[13] ^ value[12] ^ value[10];

  // A zero seed would lock the register, so it maps to the reset value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        value <= LFSR_INIT;
    else if (load)    value <= (seed == 16'h0) ? LFSR_INIT : seed;
    else if (advance) value <= {value[14:0], fb};
  end

endmodule

// File: rtl/hand_dealer.sv
// Deals 5-card hands from a 52-card deck and writes them to a player bank,
// either serially (deal) or as one parallel hand update (draw).
module hand_dealer
  import poker_pkg::*;
#(
  parameter logic [7:0] CHIP_INIT = 8'd100
)
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start_deal,
  input  logic            start_draw,
  input  logic [4:0]      replace_mask,
  input  logic            new_deck,
  input  logic            seed_load,
  input  logic [15:0]     seed,
  output logic            enable,
  output logic [2:0]      sel,
  output logic [7:0]      data,
  output logic            enable_all,
  output logic [4:0][5:0] in_card,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [5:0]      cards_left
);

  state_t state, state_nx;

  logic [15:0]                        lfsr;
  logic [15:CARD_W]                   lfsr_unused;
  card_t                              cand;
  logic [DECK_SIZE-1:0]               used, pick_bit;
  logic [63:0]                        used_ext;
  logic [HAND_SIZE-1:0][CARD_W-1:0]   hand, par_q;
  logic [2:0]                         idx;
  logic [4:0]                         mask, mask_rem;
  logic                               is_draw;
  logic                               idle, accept;
  logic                               deal_req, draw_req, deal_ok, draw_ok, err_nx;
  logic [5:0]                         left_eff;

  card_lfsr u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (idle & seed_load),
    .seed    (seed),
    .advance (state == PICK),
    .value   (lfsr)
  );

  assign {lfsr_unused, cand} = lfsr;

  // Codes 52..63 read as permanently used, so one lookup rejects both cases.
  assign used_ext = {{(64 - DECK_SIZE){1'b1}}, used};
  assign pick_bit = DECK_SIZE'(64'd1 << cand);
  assign accept   = (state == PICK) && (cand < 6'(DECK_SIZE)) && !used_ext[cand];
  assign mask_rem = mask & ~(5'b00001 << idx);

  // A same-cycle new_deck refills the deck before the start is judged.
  assign idle     = (state == IDLE);
  assign left_eff = new_deck ? 6'(DECK_SIZE) : cards_left;
  assign deal_req = idle && start_deal;
  assign draw_req = idle && start_draw && !start_deal;
  assign deal_ok  = deal_req && (left_eff >= 6'(HAND_SIZE));
  assign draw_ok  = draw_req && (left_eff >= {3'b000, popcount5(replace_mask)});
  assign err_nx   = (deal_req && !deal_ok) || (draw_req && !draw_ok);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (deal_ok)      state_nx = PICK;
        else if (draw_ok) state_nx = (replace_mask == 5'b0) ? PAR : PICK;
      end
      PICK: begin
        if (accept) begin
          if (!is_draw)              state_nx = WRITE;
          else if (mask_rem == 5'b0) state_nx = PAR;
        end
      end
      WRITE:   state_nx = (idx == 3'(HAND_SIZE - 1)) ? CHIP : PICK;
      CHIP:    state_nx = DONE;
      PAR:     state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      used       <= '0;
      cards_left <= 6'(DECK_SIZE);
      hand       <= '0;
      par_q      <= '0;
      idx        <= '0;
      mask       <= '0;
      is_draw    <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= err_nx;
      if (idle && new_deck) begin
        used       <= '0;
        cards_left <= 6'(DECK_SIZE);
      end
      if (deal_ok) begin
        idx     <= '0;
        is_draw <= 1'b0;
      end else if (draw_ok) begin
        idx     <= lowest5(replace_mask);
        mask    <= replace_mask;
        is_draw <= 1'b1;
      end
      if (accept) begin
        hand[idx]  <= cand;
        used       <= used | pick_bit;
        cards_left <= cards_left - 6'd1;
        if (is_draw) begin
          mask <= mask_rem;
          idx  <= lowest5(mask_rem);
        end
      end
      if (state == WRITE && idx != 3'(HAND_SIZE - 1)) idx <= idx + 3'd1;
      if (state == PAR) par_q <= hand;
    end
  end

  always_comb begin
    enable = 1'b0;
    sel    = 3'd0;
    data   = 8'd0;
    case (state)
      WRITE: begin
        enable = 1'b1;
        sel    = idx;
        data   = {2'b00, hand[idx]};
      end
      CHIP: begin
        enable = 1'b1;
        sel    = SEL_CHIP;
        data   = CHIP_INIT;
      end
      default: ;
    endcase
  end

  assign enable_all = (state == PAR);
  assign in_card    = (state == PAR) ? hand : par_q;
  assign busy       = !idle;
  assign done       = (state == DONE);

endmodule

// File: tb/tb_hand_dealer.sv
// Scoreboard bench for hand_dealer: a reference shuffle model predicts every
// serial write and parallel hand update; vectors and sequences drive it.
module tb_hand_dealer;
  import poker_pkg::*;

  logic            clk = 1'b0, reset = 1'b0;
  logic            start_deal = 1'b0, start_draw = 1'b0, new_deck = 1'b0, seed_load = 1'b0;
  logic [4:0]      replace_mask = '0;
  logic [15:0]     seed = '0;
  logic            enable, enable_all, busy, done, err;
  logic [2:0]      sel;
  logic [7:0]      data;
  logic [4:0][5:0] in_card;
  logic [5:0]      cards_left;

  int n_vec = 0, n_miss = 0, done_cnt = 0;

  always #5 clk = ~clk;

  hand_dealer #(.CHIP_INIT(8'd100)) dut (
    .clk(clk), .reset(reset), .start_deal(start_deal), .start_draw(start_draw),
    .replace_mask(replace_mask), .new_deck(new_deck), .seed_load(seed_load), .seed(seed),
    .enable(enable), .sel(sel), .data(data), .enable_all(enable_all), .in_card(in_card),
    .busy(busy), .done(done), .err(err), .cards_left(cards_left)
  );

  typedef struct packed {logic [2:0] sel; logic [7:0] data;} wr_t;
  wr_t             wq[$];
  logic [29:0]     pq[$];
  wr_t             mon_e;
  logic [29:0]     mon_p;
  logic [4:0][5:0] cap;

  logic [15:0]     m_lfsr;
  logic [51:0]     m_used;
  int              m_left;
  logic [4:0][5:0] m_hand;

  localparam int OP_DEAL = 0, OP_DRAW = 1, OP_BOTH = 2, OP_NEW = 3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (enable) begin
      if (sel < 3'd5) cap[sel] = data[5:0];
      if (wq.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL spurious_write: sel=%0d data=%0d with nothing expected", sel, data);
      end else begin
        mon_e = wq.pop_front();
        chk("write_sel", 32'(sel), 32'(mon_e.sel));
        chk("write_data", 32'(data), 32'(mon_e.data));
      end
    end
    if (enable_all) begin
      if (pq.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL spurious_par: in_card=%0h with nothing expected", in_card);
      end else begin
        mon_p = pq.pop_front();
        chk("par_hand", 32'(in_card), 32'(mon_p));
      end
    end
    if (done) done_cnt++;
  end

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic m_pick(output logic [5:0] c);
    logic [5:0] x;
    c = '0;
    for (int k = 0; k < 200000; k++) begin
      x = m_lfsr[5:0];
      m_lfsr = lstep(m_lfsr);
      if (x < 6'd52 && !m_used[x]) begin
        m_used[x] = 1'b1;
        m_left--;
        c = x;
        return;
      end
    end
  endtask

  task automatic m_deal();
    wr_t w;
    logic [5:0] c;
    for (int i = 0; i < 5; i++) begin
      m_pick(c);
      m_hand[i] = c;
      w.sel = 3'(i); w.data = {2'b00, c};
      wq.push_back(w);
    end
    w.sel = 3'd5; w.data = 8'd100;
    wq.push_back(w);
  endtask

  task automatic m_draw(input logic [4:0] mask);
    logic [5:0] c;
    for (int i = 0; i < 5; i++)
      if (mask[i]) begin m_pick(c); m_hand[i] = c; end
    pq.push_back(m_hand);
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 1000 && busy; t++) @(negedge clk);
  endtask

  task automatic run_op(input int op, input logic [4:0] mask, input bit nd,
                        input bit exp_err, input int exp_left, input string tag);
    int t;
    wait_idle();
    if (nd || op == OP_NEW) begin m_used = '0; m_left = 52; end
    if (!exp_err) begin
      if (op == OP_DEAL || op == OP_BOTH) m_deal();
      else if (op == OP_DRAW)             m_draw(mask);
    end
    start_deal   = (op == OP_DEAL || op == OP_BOTH);
    start_draw   = (op == OP_DRAW || op == OP_BOTH);
    replace_mask = mask;
    new_deck     = nd || op == OP_NEW;
    @(negedge clk);
    start_deal = 1'b0; start_draw = 1'b0; new_deck = 1'b0; replace_mask = '0;
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    if (op == OP_DRAW && mask == 5'b0 && !exp_err)
      chk({tag, "_par_next"}, 32'(enable_all), 32'd1);
    if (op != OP_NEW && !exp_err) begin
      t = 0;
      while (!done && t < 60000) begin @(negedge clk); t++; end
      chk({tag, "_done"}, 32'(done), 32'd1);
    end
    @(negedge clk);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_left"}, 32'(cards_left), 32'(exp_left));
    chk({tag, "_sb_drained"}, 32'(wq.size() + pq.size()), 32'd0);
  endtask

  task automatic seed_op(input logic [15:0] s);
    wait_idle();
    seed_load = 1'b1; seed = s;
    @(negedge clk);
    seed_load = 1'b0;
    m_lfsr = (s == 16'h0) ? 16'hACE1 : s;
  endtask

  typedef struct {int op; logic [4:0] mask; bit nd; bit exp_err; int exp_left;} vec_t;
  vec_t tbl[8];

  initial begin
    logic [4:0][5:0] ref_cap;
    int dc;
    int t;
    tbl[0] = '{OP_DEAL, 5'b00000, 1'b0, 1'b0, 47};
    tbl[1] = '{OP_DRAW, 5'b10101, 1'b0, 1'b0, 44};
    tbl[2] = '{OP_DRAW, 5'b00000, 1'b0, 1'b0, 44};
    tbl[3] = '{OP_BOTH, 5'b11111, 1'b0, 1'b0, 39};
    tbl[4] = '{OP_DRAW, 5'b11111, 1'b0, 1'b0, 34};
    tbl[5] = '{OP_NEW,  5'b00000, 1'b0, 1'b0, 52};
    tbl[6] = '{OP_DRAW, 5'b00001, 1'b0, 1'b0, 51};
    tbl[7] = '{OP_DEAL, 5'b00000, 1'b1, 1'b0, 47};

    m_lfsr = 16'hACE1; m_used = '0; m_left = 52; m_hand = '0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_left", 32'(cards_left), 32'd52);
    chk("rst_write", 32'({enable, sel, data}), 32'd0);
    chk("rst_par", 32'({enable_all, in_card}), 32'd0);
    chk("rst_status", 32'({done, err}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_op(tbl[i].op, tbl[i].mask, tbl[i].nd, tbl[i].exp_err, tbl[i].exp_left,
             $sformatf("vec%0d", i));

    // Drain the deck without refills, then probe the shortage boundaries.
    run_op(OP_NEW, 5'b0, 1'b0, 1'b0, 52, "refill");
    for (int i = 0; i < 10; i++)
      run_op(OP_DEAL, 5'b0, 1'b0, 1'b0, 47 - 5 * i, $sformatf("deal%0d", i));
    run_op(OP_DEAL, 5'b0,     1'b0, 1'b1, 2, "deal_short");
    run_op(OP_DRAW, 5'b11111, 1'b0, 1'b1, 2, "draw_short");
    run_op(OP_DRAW, 5'b00011, 1'b0, 1'b0, 0, "draw_last2");
    run_op(OP_DRAW, 5'b00001, 1'b0, 1'b1, 0, "draw_empty");
    run_op(OP_DRAW, 5'b00000, 1'b0, 1'b0, 0, "draw_none_empty");
    run_op(OP_DEAL, 5'b0,     1'b1, 1'b0, 47, "deal_refill");

    // Every start, refill and seed pulse mid-deal must be ignored.
    wait_idle();
    m_deal();
    start_deal = 1'b1;
    @(negedge clk);
    start_deal = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_mid_deal", 32'(busy), 32'd1);
    start_deal = 1'b1; start_draw = 1'b1; replace_mask = 5'b11111;
    new_deck = 1'b1; seed_load = 1'b1; seed = 16'h5555;
    @(negedge clk);
    start_deal = 1'b0; start_draw = 1'b0; replace_mask = '0; new_deck = 1'b0; seed_load = 1'b0;
    t = 0;
    while (!done && t < 60000) begin @(negedge clk); t++; end
    chk("busy_ign_done", 32'(done), 32'd1);
    @(negedge clk);
    chk("busy_ign_left", 32'(cards_left), 32'd42);
    chk("busy_ign_sb", 32'(wq.size()), 32'd0);
    run_op(OP_DRAW, 5'b01010, 1'b0, 1'b0, 40, "after_ign");

    // Reset during the third serial write.
    wait_idle();
    m_deal();
    start_deal = 1'b1;
    @(negedge clk);
    start_deal = 1'b0;
    t = 0;
    while (!(enable && sel == 3'd2) && t < 60000) begin @(negedge clk); t++; end
    chk("mid_rst_reached", 32'({enable, sel}), 32'({1'b1, 3'd2}));
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_write", 32'({enable, sel, data}), 32'd0);
    chk("mid_rst_par", 32'({enable_all, in_card}), 32'd0);
    chk("mid_rst_busy", 32'({busy, done}), 32'd0);
    chk("mid_rst_left", 32'(cards_left), 32'd52);
    wq.delete();
    m_lfsr = 16'hACE1; m_used = '0; m_left = 52; m_hand = '0;
    dc = done_cnt;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_rst_no_done", 32'(done_cnt), 32'(dc));
    run_op(OP_DEAL, 5'b0, 1'b0, 1'b0, 47, "post_rst");

    // Seed repeatability, and zero seed aliasing the default seed.
    seed_op(16'h1234);
    run_op(OP_DEAL, 5'b0, 1'b1, 1'b0, 47, "seedA");
    ref_cap = cap;
    seed_op(16'h1234);
    run_op(OP_DEAL, 5'b0, 1'b1, 1'b0, 47, "seedB");
    for (int i = 0; i < 5; i++) chk($sformatf("seed_rep%0d", i), 32'(cap[i]), 32'(ref_cap[i]));
    seed_op(16'h0000);
    run_op(OP_DEAL, 5'b0, 1'b1, 1'b0, 47, "seed0");
    ref_cap = cap;
    seed_op(16'hACE1);
    run_op(OP_DEAL, 5'b0, 1'b1, 1'b0, 47, "seedACE1");
    for (int i = 0; i < 5; i++) chk($sformatf("seed_zero%0d", i), 32'(cap[i]), 32'(ref_cap[i]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: run exceeded its cycle budget");
    $fatal(1);
  end

endmodule

// File: doc/hand_dealer.md
HAND_DEALER -- requirements
Module: hand_dealer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; clock and reset SHALL be named clk and reset.
REQ-002 Parameter CHIP_INIT, default 8'd100, SHALL set the chip value written to a player at each deal.
REQ-003 clk  input  1  system clock.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 start_deal  input  1  single-cycle pulse: deal a fresh 5-card hand.
REQ-006 start_draw  input  1  single-cycle pulse: replace the cards flagged in replace_mask.
REQ-007 replace_mask  input  5  card slots to replace; sampled on start_draw.
REQ-008 new_deck  input  1  returns all 52 cards to the deck; honoured in IDLE only.
REQ-009 seed_load / seed  input  1 / 16  loads the shuffle LFSR; honoured in IDLE only.
REQ-010 enable, sel, data  output  1, 3, 8  serial write port to the player bank.
REQ-011 enable_all, in_card[5]  output  1, 5x6  parallel hand write port to the player bank.
REQ-012 busy, done, err  output  1, 1, 1  status; done and err are single-cycle pulses.
REQ-013 cards_left  output  6  undealt cards remaining in the deck.

Function
REQ-014 Card codes SHALL be 0..51; codes 52..63 SHALL never appear on data or in_card.
REQ-015 The FSM SHALL have the states IDLE, PICK, WRITE, CHIP, PAR and DONE; busy SHALL be 1 in every state except IDLE.
REQ-016 In PICK, each cycle SHALL test candidate lfsr[5:0]; a candidate SHALL be accepted only if it is <52 and its used bit is 0.
REQ-017 The LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, and SHALL advance every cycle in PICK.
REQ-018 On accept, the block SHALL store the card in hand[idx], set its used bit and decrement cards_left, all in the same cycle.
REQ-019 Deal: IDLE + start_deal SHALL set idx=0 and enter PICK; after each accept the block SHALL enter WRITE.
REQ-020 In WRITE, for exactly one cycle, outputs SHALL be enable=1, sel=idx, data={2'b00,card}; idx<4 -> PICK with idx+1; idx==4 -> CHIP.
REQ-021 In CHIP, for one cycle, outputs SHALL be enable=1, sel=3'd5, data=CHIP_INIT; the next state SHALL be DONE.
REQ-022 Draw: IDLE + start_draw SHALL latch replace_mask and replace the flagged slots in ascending index order via PICK with no serial writes; when the last flagged slot is done, the next state SHALL be PAR.
REQ-023 Draw with replace_mask==0 SHALL go directly from IDLE to PAR.
REQ-024 In PAR, for one cycle, outputs SHALL be enable_all=1 and in_card=hand[0..4]; the next state SHALL be DONE.
REQ-025 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-026 Outside WRITE/CHIP, enable=0, sel=0 and data=0; outside PAR, enable_all=0 and in_card holds its last value.
REQ-027 start_deal and start_draw in the same cycle: the deal SHALL win.
REQ-028 Start pulses while busy SHALL be ignored.
REQ-029 Insufficient deck (start_deal with cards_left<5, or start_draw with cards_left<popcount(mask)): the block SHALL pulse err, perform no writes, change no state and remain in IDLE.
REQ-030 new_deck in IDLE SHALL clear the used mask and set cards_left=52 in one cycle; it SHALL be ignored when busy.
REQ-031 seed_load SHALL load seed into the LFSR; seed==0 SHALL load 16'hACE1 instead.
REQ-032 A start_* and new_deck in the same IDLE cycle: new_deck SHALL apply first, then the start proceeds against the full deck.

Reset
REQ-033 Reset SHALL set state=IDLE, lfsr=16'hACE1, used mask=0, cards_left=52, hand=0, idx=0 and all outputs=0.
REQ-034 Reset mid-deal or mid-draw SHALL abort immediately with no further writes and no done pulse.

Structure
REQ-035 Package poker_pkg SHALL hold CARD_W=6, HAND_SIZE=5, DECK_SIZE=52, SEL_CHIP=3'd5, typedef card_t and the FSM state enum.
REQ-036 The LFSR SHALL be a separate sub-module card_lfsr (ports: clk, reset, load, seed, advance, value).

Verification
REQ-037 Reset, then start_deal -> exactly 5 writes with sel=0..4, each data<52 and distinct, then sel=5 with data=100, then a done pulse; cards_left=47.
REQ-038 Ten back-to-back deals with no new_deck -> first 10 deals succeed with 50 unique cards total and cards_left=2; the 11th start_deal -> err pulse, no enable.
REQ-039 After a deal, start_draw with mask=5'b10101 -> slots 1 and 3 unchanged, slots 0/2/4 new and unique versus all dealt cards; enable_all high exactly 1 cycle; cards_left drops by 3.
REQ-040 start_draw with mask=0 -> PAR after 1 cycle, in_card equals the prior hand, cards_left unchanged.
REQ-041 Reset asserted during the 3rd WRITE -> all outputs 0 the same cycle, cards_left=52, no done pulse; a subsequent deal completes normally.
REQ-042 Identical seed loads (16'h1234) followed by identical deals -> identical card sequences; seed=0 gives the same sequence as seed 16'hACE1.
